// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
//
// Parametrised coin-operated vending controller. Coins arrive on A/B/C with
// configurable values; credit accumulates until it reaches PRICE. The machine
// then vends for one cycle and pays change back one CHANGE_UNIT per cycle.
// A cancel request refunds the current credit. Rejected coins are flagged
// with a one-cycle coin_reject pulse.
//
// Compile-time option:
//   VM_TIMEOUT_EN - when defined, TIMEOUT_CYC idle cycles in CREDIT trigger an
//                   automatic refund. When undefined, CREDIT persists forever.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   A, B, C      coin present levels (one coin per rising edge)
//   cancel       refund request, level-sampled (honoured in CREDIT only)
//   state        FSM state: 0 IDLE, 1 CREDIT, 2 VEND, 3 CHANGE
//   y            y[1] = dispense, y[0] = change pulse
//   credit       current credit
//   coin_reject  one-cycle pulse when a detected coin is refused
// -----------------------------------------------------------------------------
module vending_machine_param #(
  parameter int CREDIT_W    = 6,
  parameter int PRICE       = 15,
  parameter int VAL_A       = 5,
  parameter int VAL_B       = 10,
  parameter int VAL_C       = 20,
  parameter int CHANGE_UNIT = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                A,
  input  logic                B,
  input  logic                C,
  input  logic                cancel,
  output logic [1:0]          state,
  output logic [1:0]          y,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject
);

  // Sums are formed one bit wider than the credit register so overflow is visible.
  localparam int                  W1         = CREDIT_W + 1;
  localparam logic [W1-1:0]       MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [W1-1:0]       PRICE_X    = W1'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT       = CREDIT_W'(CHANGE_UNIT);

  if ((TIMEOUT_CYC < 1) || (PRICE < 1) || (CHANGE_UNIT < 1)) begin : g_bad_params
    $error("vending_machine_param: TIMEOUT_CYC, PRICE and CHANGE_UNIT must be positive");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [CREDIT_W-1:0] credit_r, credit_nxt_s;
  logic                a_r, b_r, c_r;
  logic [2:0]          ev_s;
  logic [W1-1:0]       coin_val_s, sum_s;
  logic                one_ev_s, overflow_s, accept_s, reject_s, timeout_s;
  logic                coin_reject_r;
  logic [1:0]          y_r, y_nxt_s;

  // Rising-edge detect: a coin held high is counted once.
  assign ev_s       = {C & ~c_r, B & ~b_r, A & ~a_r};
  assign one_ev_s   = $onehot(ev_s);
  assign sum_s      = {1'b0, credit_r} + coin_val_s;
  assign overflow_s = (sum_s > MAX_CREDIT);

`ifdef VM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_r;

  assign timeout_s = (state_r == ST_CREDIT) && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  // Idle counter: runs only while sitting in CREDIT without accepting a coin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r != ST_CREDIT) || (state_nxt_s != state_r) || accept_s) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Value of the single detected coin (zero when none or several).
  always_comb begin
    coin_val_s = {W1{1'b0}};
    case (ev_s)
      3'b001:  coin_val_s = W1'(VAL_A);
      3'b010:  coin_val_s = W1'(VAL_B);
      3'b100:  coin_val_s = W1'(VAL_C);
      default: coin_val_s = {W1{1'b0}};
    endcase
  end

  // Next-state, next-credit and coin accept/reject decision.
  always_comb begin
    state_nxt_s  = state_r;
    credit_nxt_s = credit_r;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_CREDIT: begin
        if (one_ev_s && !overflow_s) begin
          accept_s = 1'b1;
          // The coin is added first; the price check sees the new total.
          if (sum_s >= PRICE_X) begin
            credit_nxt_s = CREDIT_W'(sum_s - PRICE_X);
            state_nxt_s  = ST_VEND;
          end else begin
            credit_nxt_s = CREDIT_W'(sum_s);
            if ((state_r == ST_CREDIT) && cancel) begin
              state_nxt_s = ST_CHANGE;
            end else begin
              state_nxt_s = ST_CREDIT;
            end
          end
        end else begin
          reject_s = |ev_s;
          if ((state_r == ST_CREDIT) && (cancel || timeout_s)) begin
            state_nxt_s = ST_CHANGE;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      ST_VEND: begin
        reject_s = |ev_s;
        if (credit_r >= UNIT) begin
          state_nxt_s = ST_CHANGE;
        end else begin
          state_nxt_s  = ST_IDLE;
          credit_nxt_s = {CREDIT_W{1'b0}};
        end
      end
      ST_CHANGE: begin
        reject_s = |ev_s;
        if (credit_r <= UNIT) begin
          state_nxt_s  = ST_IDLE;
          credit_nxt_s = {CREDIT_W{1'b0}};
        end else begin
          credit_nxt_s = credit_r - UNIT;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        credit_nxt_s = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // Moore output decode, computed from the next state so y is registered with it.
  always_comb begin
    y_nxt_s = 2'b00;
    case (state_nxt_s)
      ST_VEND:   y_nxt_s = 2'b10;
      ST_CHANGE: y_nxt_s = 2'b01;
      default:   y_nxt_s = 2'b00;
    endcase
  end

  // State, credit, coin edge history and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      credit_r      <= {CREDIT_W{1'b0}};
      a_r           <= 1'b0;
      b_r           <= 1'b0;
      c_r           <= 1'b0;
      y_r           <= 2'b00;
      coin_reject_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      credit_r      <= credit_nxt_s;
      a_r           <= A;
      b_r           <= B;
      c_r           <= C;
      y_r           <= y_nxt_s;
      coin_reject_r <= reject_s;
    end
  end

  assign state       = state_r;
  assign credit      = credit_r;
  assign y           = y_r;
  assign coin_reject = coin_reject_r;

endmodule
